mac_sched: RTL and testbench
============================

Name: mac_sched

Overview:
- Round-robin scheduler that shares the single 4x4 MAC/averager datapath between NUM_REQ operand requesters.
- Each requester is granted a complete averaging window of WIN_LEN operand pairs, so one average never mixes data from different requesters.
- Drives the MAC write-side operand inputs and obeys its Wfull backpressure.
- Emits a per-window owner tag so downstream logic can route each AverageOut to its requester.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_W, 4: operand width; matches MAC DataIn1/DataIn2.
- WIN_LEN, 4: operand pairs per averaging window; matches the MAC divide-by-4.
- TIMEOUT, 16: idle cycles tolerated mid-window before the window is padded and closed.

Ports:
- Wclk  in  1  sole clock; MAC write-side clock.
- Reset  in  1  synchronous, active-high reset.
- ReqValid  in  NUM_REQ  per-requester operand pair valid.
- ReqA  in  NUM_REQ*DATA_W  packed operand A; requester r occupies bits [r*DATA_W +: DATA_W].
- ReqB  in  NUM_REQ*DATA_W  packed operand B; same packing as ReqA.
- ReqReady  out  NUM_REQ  per-requester accept.
- Wfull  in  1  MAC write FIFO full.
- DataIn1  out  DATA_W  operand A to MAC.
- DataIn2  out  DATA_W  operand B to MAC.
- WrEn  out  1  operand pair on DataIn1/DataIn2 is valid this cycle.
- WinTag  out  $clog2(NUM_REQ)  owner of the window just closed.
- WinDone  out  1  one-cycle pulse: window closed; WinTag valid.
- WinAbort  out  1  with WinDone: window closed by timeout padding.
- Busy  out  1  a window is in progress.

Behaviour:
- Reset (synchronous, Wclk rising edge, Reset=1) forces: DataIn1=0, DataIn2=0, WrEn=0, WinTag=0, WinDone=0, WinAbort=0, Busy=0, ReqReady=0. State=IDLE, RR pointer=0, beat and timeout counters=0.
- Reset asserted mid-window discards the partial window. No WinDone is emitted for it.
- State IDLE:
  - Busy=0.
  - If any ReqValid is set, grant the first set requester at or after the pointer (wrapping).
  - Latch the grant index g and go to XFER next cycle. No beat is accepted in the grant cycle.
- State XFER:
  - Busy=1.
  - ReqReady[g] = !Wfull (combinational). All other ReqReady bits = 0.
  - A beat is accepted when ReqValid[g] && ReqReady[g].
  - The accepted pair appears on DataIn1/DataIn2 with WrEn=1 exactly one cycle later (registered).
  - WrEn=0 in every cycle with no accepted beat. DataIn1/DataIn2 hold their last value.
  - The beat counter increments per accepted beat.
  - On the WIN_LEN-th beat: go to DONE.
- Wfull=1 stalls acceptance. It never advances the timeout counter.
- Timeout counter:
  - Counts XFER cycles with Wfull=0 and ReqValid[g]=0. Clears on each accepted beat.
  - Reaching TIMEOUT enters PAD.
- State PAD:
  - ReqReady all 0.
  - Injects zero pairs (0,0), one per cycle while Wfull=0, until the beat counter reaches WIN_LEN.
  - Then goes to DONE with the abort flag set.
- State DONE (one cycle):
  - WinDone=1, WinTag=g, WinAbort=abort flag.
  - Pointer = g+1, wrapping at NUM_REQ to 0.
  - Return to IDLE; re-arbitration happens in that IDLE cycle.
- The maximum sustained rate is WIN_LEN beats per WIN_LEN+2 cycles.
- The grant is held for the full window regardless of higher-priority ReqValid.
- Operands are passed through unmodified. No arithmetic is done in this block.
- Simultaneous events:
  - Wfull rising in the same cycle as ReqValid[g]: beat not accepted. Requester must hold data (valid/ready rule; ReqA/ReqB stable while ReqValid && !ReqReady).
  - Timeout reached in the same cycle ReqValid[g] rises: timeout wins, enter PAD.

Decomposition:
- Shared package mac_pkg holds:
  - State enum (IDLE, XFER, PAD, DONE).
  - Defaults DATA_W=4, WIN_LEN=4.
  - Function for round-robin index search.
- One sub-module, rr_arbiter: NUM_REQ request vector plus pointer in, one-hot grant and encoded index out. Purely combinational.
- Window FSM, counters and output registers live in mac_sched.

Test Plan:
- Single requester: requester 0 streams pairs (1,2),(3,4),(5,6),(7,8) with Wfull=0.
  - DataIn1/DataIn2 show them with WrEn on 4 consecutive cycles, each 1 cycle after acceptance.
  - WinDone with WinTag=0, WinAbort=0.
- Fairness: all 4 requesters hold ReqValid=1 continuously.
  - Window owners are 0,1,2,3,0.
  - No window mixes sources; checked by tagging operand values per requester.
- Backpressure: Wfull=1 for 5 cycles after the 2nd beat.
  - ReqReady[g]=0 and WrEn=0 during the stall.
  - No beat is lost or duplicated. The window completes with 4 beats.
- Timeout: requester 2 sends 2 beats then drops ReqValid, with TIMEOUT=16.
  - After 16 idle cycles, two (0,0) pairs appear with WrEn.
  - WinDone with WinTag=2, WinAbort=1.
- Reset mid-window: Reset pulsed after the 3rd beat.
  - All outputs 0 the next cycle and no WinDone.
  - The next window starts from requester 0 and has 4 fresh beats.
- Grant lock: requester 3 granted; requester 0 asserts ReqValid mid-window.
  - Requester 3 finishes its 4 beats.
  - Requester 0 is granted next.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC operand scheduler: window FSM states,
// default widths and the round-robin search used by the arbiter.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        PAD  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DATA_W_DEF  = 4;
    localparam int WIN_LEN_DEF = 4;
    localparam int MAX_REQ     = 8;

    // First set request at or after ptr, wrapping at n; returns 0 if none is set.
    function automatic int rr_search(input logic [MAX_REQ-1:0] req,
                                     input int ptr,
                                     input int n);
        int  j;
        int  idx;
        bit  found;
        idx   = 0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            j = ptr + i;
            if (j >= n) j = j - n;
            if (i < n && !found && j >= 0 && j < MAX_REQ) begin
                if (req[j[2:0]]) begin
                    idx   = j;
                    found = 1'b1;
                end
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mac_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request at or
// after the pointer and reports it both one-hot and encoded.
module rr_arbiter
    import mac_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [MAX_REQ-1:0] req_ext;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
        idx                    = IDX_W'(rr_search(req_ext, int'(ptr), NUM_REQ));
        any                    = |req;
        grant                  = '0;
        if (any) grant[idx] = 1'b1;
    end

endmodule

// File: rtl/mac_sched.sv
// Round-robin scheduler sharing one MAC/averager between NUM_REQ requesters,
// one whole WIN_LEN-pair window per grant, with timeout padding of stalled windows.
module mac_sched
    import mac_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int WIN_LEN = WIN_LEN_DEF,
    parameter int TIMEOUT = 16,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic                      Wclk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        ReqValid,
    input  logic [NUM_REQ*DATA_W-1:0] ReqA,
    input  logic [NUM_REQ*DATA_W-1:0] ReqB,
    output logic [NUM_REQ-1:0]        ReqReady,
    input  logic                      Wfull,
    output logic [DATA_W-1:0]         DataIn1,
    output logic [DATA_W-1:0]         DataIn2,
    output logic                      WrEn,
    output logic [IDX_W-1:0]          WinTag,
    output logic                      WinDone,
    output logic                      WinAbort,
    output logic                      Busy,
    output state_t                    DbgState
);

    localparam int BEAT_W = $clog2(WIN_LEN + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   gidx_q, ptr_q, arb_idx;
    logic [NUM_REQ-1:0] goh_q, arb_grant;
    logic               arb_any;
    logic [BEAT_W-1:0]  beat_q;
    logic [TMO_W-1:0]   tmo_q;
    logic               abort_q;
    logic               sel_valid;
    logic [DATA_W-1:0]  sel_a, sel_b;
    logic               accept, pad_beat, last_beat, tmo_hit;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req   (ReqValid),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Handshake: a pair moves when ReqValid[r] && ReqReady[r] at a Wclk edge;
    // the requester must hold ReqA/ReqB stable while ReqValid && !ReqReady.
    always_comb begin
        sel_valid = |(ReqValid & goh_q);
        sel_a     = ReqA[gidx_q*DATA_W +: DATA_W];
        sel_b     = ReqB[gidx_q*DATA_W +: DATA_W];
        last_beat = (beat_q == BEAT_W'(WIN_LEN - 1));
        accept    = (state_q == XFER) && sel_valid && !Wfull;
        pad_beat  = (state_q == PAD) && !Wfull;
        tmo_hit   = (state_q == XFER) && !Wfull && !sel_valid &&
                    (tmo_q == TMO_W'(TIMEOUT - 1));
    end

    always_ff @(posedge Wclk) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (arb_any) state_d = XFER;
            XFER: begin
                if (accept && last_beat) state_d = DONE;
                else if (tmo_hit)        state_d = PAD;
            end
            PAD:  if (pad_beat && last_beat) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ReqReady = ((state_q == XFER) && !Wfull) ? goh_q : '0;
        WinDone  = (state_q == DONE);
        WinTag   = WinDone ? gidx_q : '0;
        WinAbort = WinDone && abort_q;
        Busy     = (state_q != IDLE);
        DbgState = state_q;
    end

    always_ff @(posedge Wclk) begin
        if (Reset) begin
            DataIn1 <= '0;
            DataIn2 <= '0;
            WrEn    <= 1'b0;
            gidx_q  <= '0;
            goh_q   <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
            tmo_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            WrEn <= accept || pad_beat;
            if (accept) begin
                DataIn1 <= sel_a;
                DataIn2 <= sel_b;
            end else if (pad_beat) begin
                DataIn1 <= '0;
                DataIn2 <= '0;
            end
            case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        gidx_q  <= arb_idx;
                        goh_q   <= arb_grant;
                        beat_q  <= '0;
                        tmo_q   <= '0;
                        abort_q <= 1'b0;
                    end
                end
                XFER: begin
                    // Stalls under Wfull neither count as idle nor clear the count.
                    if (accept) begin
                        beat_q <= beat_q + 1'b1;
                        tmo_q  <= '0;
                    end else if (!Wfull && !sel_valid) begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                    if (tmo_hit) abort_q <= 1'b1;
                end
                PAD: begin
                    if (pad_beat) beat_q <= beat_q + 1'b1;
                end
                DONE: begin
                    ptr_q <= (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_sched.sv
// Bench for mac_sched: directed scenarios plus random traffic, checked against
// a window-level reference model of arbitration, timeout padding and delivery.
module tb_mac_sched;
  import mac_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 4;
  localparam int WIN_LEN = 4;
  localparam int TIMEOUT = 16;
  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int PW      = 2 * DATA_W;

  localparam int M_ARB   = 0;
  localparam int M_XFER  = 1;
  localparam int M_PAD   = 2;
  localparam int M_CLOSE = 3;

  // ---------------- clock / reset ----------------
  logic                      Wclk = 1'b0;
  logic                      Reset;
  logic [NUM_REQ-1:0]        ReqValid;
  logic [NUM_REQ*DATA_W-1:0] ReqA, ReqB;
  logic [NUM_REQ-1:0]        ReqReady;
  logic                      Wfull;
  logic [DATA_W-1:0]         DataIn1, DataIn2;
  logic                      WrEn;
  logic [IDX_W-1:0]          WinTag;
  logic                      WinDone, WinAbort, Busy;
  state_t                    DbgState;

  always #5 Wclk = ~Wclk;

  mac_sched #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .WIN_LEN(WIN_LEN), .TIMEOUT(TIMEOUT)) dut (
    .Wclk(Wclk), .Reset(Reset), .ReqValid(ReqValid), .ReqA(ReqA), .ReqB(ReqB),
    .ReqReady(ReqReady), .Wfull(Wfull), .DataIn1(DataIn1), .DataIn2(DataIn2),
    .WrEn(WrEn), .WinTag(WinTag), .WinDone(WinDone), .WinAbort(WinAbort),
    .Busy(Busy), .DbgState(DbgState)
  );

  // ---------------- bench state ----------------
  int checks = 0;
  int failures = 0;

  logic [PW-1:0]      srcq [NUM_REQ][$];
  logic [PW-1:0]      exp_q[$];
  logic [NUM_REQ-1:0] en;
  logic               wfull_drv;

  int m_phase, m_owner, m_ptr, m_beats, m_idle;
  bit m_abort, m_push;
  logic [PW-1:0] last_pair;

  int done_cnt = 0;
  int hs_total = 0;
  int obs_tags[$];
  int obs_aborts[$];
  int obs_beats[$];
  int win_beats;
  bit tag_check;
  logic [DATA_W-1:0] win_a[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int ptr);
    int idx;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (ptr + k) % NUM_REQ;
      if (v[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_phase   = M_ARB;
    m_ptr     = 0;
    m_owner   = 0;
    m_beats   = 0;
    m_idle    = 0;
    m_abort   = 1'b0;
    m_push    = 1'b0;
    last_pair = '0;
    win_beats = 0;
    exp_q.delete();
    win_a.delete();
  endtask

  // ---------------- driver ----------------
  task automatic drive();
    for (int r = 0; r < NUM_REQ; r++) begin
      ReqValid[r] = en[r] && (srcq[r].size() > 0);
      if (ReqValid[r]) begin
        ReqA[r*DATA_W +: DATA_W] = srcq[r][0][PW-1:DATA_W];
        ReqB[r*DATA_W +: DATA_W] = srcq[r][0][DATA_W-1:0];
      end else begin
        ReqA[r*DATA_W +: DATA_W] = '0;
        ReqB[r*DATA_W +: DATA_W] = '0;
      end
    end
    Wfull = wfull_drv;
  endtask

  // Reference model for one cycle, from the inputs the requesters present.
  task automatic model_step(output logic [NUM_REQ-1:0] exp_ready);
    exp_ready = '0;
    m_push    = 1'b0;
    case (m_phase)
      M_ARB: begin
        if (ReqValid != '0) begin
          m_owner = rr_pick(ReqValid, m_ptr);
          m_beats = 0;
          m_idle  = 0;
          m_abort = 1'b0;
          m_phase = M_XFER;
        end
      end
      M_XFER: begin
        if (!Wfull) exp_ready[m_owner] = 1'b1;
        if (!Wfull && ReqValid[m_owner]) begin
          exp_q.push_back({ReqA[m_owner*DATA_W +: DATA_W], ReqB[m_owner*DATA_W +: DATA_W]});
          m_push = 1'b1;
          m_beats++;
          m_idle = 0;
          if (m_beats == WIN_LEN) m_phase = M_CLOSE;
        end else if (!Wfull) begin
          m_idle++;
          if (m_idle == TIMEOUT) m_phase = M_PAD;
        end
      end
      M_PAD: begin
        if (!Wfull) begin
          exp_q.push_back('0);
          m_push = 1'b1;
          m_beats++;
          if (m_beats == WIN_LEN) begin
            m_abort = 1'b1;
            m_phase = M_CLOSE;
          end
        end
      end
      default: begin
        m_ptr   = (m_owner + 1) % NUM_REQ;
        m_phase = M_ARB;
      end
    endcase
  endtask

  // One Wclk cycle: drive at negedge, check ReqReady before the edge,
  // check registered outputs #1 after the edge.
  task automatic tick(input bit rst);
    logic [NUM_REQ-1:0] exp_ready;
    logic [NUM_REQ-1:0] hs;
    logic [PW-1:0] exp_pair;
    Reset = rst;
    drive();
    #1;
    exp_ready = '0;
    if (!rst) begin
      model_step(exp_ready);
      chk("req_ready", 32'(ReqReady), 32'(exp_ready));
    end
    hs = rst ? '0 : (ReqValid & ReqReady);
    @(posedge Wclk);
    #1;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (hs[r]) begin
        void'(srcq[r].pop_front());
        hs_total++;
      end
    end
    if (rst) begin
      model_reset();
      chk("rst_wren", 32'(WrEn), 32'd0);
      chk("rst_data1", 32'(DataIn1), 32'd0);
      chk("rst_data2", 32'(DataIn2), 32'd0);
      chk("rst_tag", 32'(WinTag), 32'd0);
      chk("rst_done", 32'(WinDone), 32'd0);
      chk("rst_abort", 32'(WinAbort), 32'd0);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_ready", 32'(ReqReady), 32'd0);
    end else begin
      chk("wren", 32'(WrEn), 32'(m_push));
      if (m_push) begin
        exp_pair  = exp_q.pop_front();
        last_pair = exp_pair;
        chk("data_out", 32'({DataIn1, DataIn2}), 32'(exp_pair));
        win_beats++;
        win_a.push_back(DataIn1);
      end else begin
        chk("data_hold", 32'({DataIn1, DataIn2}), 32'(last_pair));
      end
      if (m_phase == M_CLOSE) begin
        chk("win_done", 32'(WinDone), 32'd1);
        chk("win_tag", 32'(WinTag), 32'(m_owner));
        chk("win_abort", 32'(WinAbort), 32'(m_abort));
        obs_tags.push_back(int'(WinTag));
        obs_aborts.push_back(int'(WinAbort));
        obs_beats.push_back(win_beats);
        if (tag_check && !m_abort) begin
          foreach (win_a[i]) chk("win_source", 32'(win_a[i]), 32'(WinTag));
        end
        win_beats = 0;
        win_a.delete();
        done_cnt++;
      end else begin
        chk("win_done_idle", 32'(WinDone), 32'd0);
        chk("win_abort_idle", 32'(WinAbort), 32'd0);
      end
      if (m_phase == M_XFER || m_phase == M_PAD) chk("busy", 32'(Busy), 32'd1);
      else if (m_phase == M_ARB) chk("idle_busy", 32'(Busy), 32'd0);
    end
    @(negedge Wclk);
  endtask

  task automatic do_reset();
    for (int r = 0; r < NUM_REQ; r++) srcq[r].delete();
    en        = '1;
    wfull_drv = 1'b0;
    tick(1'b1);
    Reset = 1'b0;
  endtask

  task automatic run_windows(input int n, input int budget);
    int target;
    target = done_cnt + n;
    for (int i = 0; i < budget && done_cnt < target; i++) tick(1'b0);
    chk("window_budget", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic run_beats(input int n, input int budget);
    int target;
    target = hs_total + n;
    for (int i = 0; i < budget && hs_total < target; i++) tick(1'b0);
    chk("beat_budget", 32'(hs_total >= target), 32'd1);
  endtask

  task automatic push_pair(input int r, input int a, input int b);
    srcq[r].push_back({DATA_W'(a), DATA_W'(b)});
  endtask

  // ---------------- directed + random steps ----------------
  initial begin
    int base;
    int dones_before;
    int pending;
    Reset     = 1'b1;
    ReqValid  = '0;
    ReqA      = '0;
    ReqB      = '0;
    Wfull     = 1'b0;
    en        = '1;
    wfull_drv = 1'b0;
    tag_check = 1'b0;
    model_reset();
    @(negedge Wclk);
    do_reset();

    // Single requester stream
    push_pair(0, 1, 2);
    push_pair(0, 3, 4);
    push_pair(0, 5, 6);
    push_pair(0, 7, 8);
    run_windows(1, 40);
    chk("single_tag", 32'(obs_tags[$]), 32'd0);
    chk("single_abort", 32'(obs_aborts[$]), 32'd0);
    chk("single_beats", 32'(obs_beats[$]), 32'd4);

    // Fairness: everyone valid continuously, operands tagged by source
    do_reset();
    tag_check = 1'b1;
    for (int r = 0; r < NUM_REQ; r++)
      for (int k = 0; k < 2 * WIN_LEN; k++) push_pair(r, r, k);
    base = obs_tags.size();
    run_windows(5, 100);
    chk("fair_owner0", 32'(obs_tags[base + 0]), 32'd0);
    chk("fair_owner1", 32'(obs_tags[base + 1]), 32'd1);
    chk("fair_owner2", 32'(obs_tags[base + 2]), 32'd2);
    chk("fair_owner3", 32'(obs_tags[base + 3]), 32'd3);
    chk("fair_owner4", 32'(obs_tags[base + 4]), 32'd0);
    run_windows(3, 100);
    tag_check = 1'b0;

    // Backpressure after the second beat
    do_reset();
    for (int k = 0; k < WIN_LEN; k++) push_pair(1, 9, k + 1);
    run_beats(2, 20);
    wfull_drv = 1'b1;
    repeat (5) tick(1'b0);
    chk("stall_ready", 32'(ReqReady), 32'd0);
    chk("stall_wren", 32'(WrEn), 32'd0);
    wfull_drv = 1'b0;
    run_windows(1, 40);
    chk("bp_tag", 32'(obs_tags[$]), 32'd1);
    chk("bp_beats", 32'(obs_beats[$]), 32'd4);

    // Timeout padding
    do_reset();
    push_pair(2, 10, 11);
    push_pair(2, 12, 13);
    run_windows(1, 60);
    chk("tmo_tag", 32'(obs_tags[$]), 32'd2);
    chk("tmo_abort", 32'(obs_aborts[$]), 32'd1);
    chk("tmo_beats", 32'(obs_beats[$]), 32'd4);

    // Reset mid-window discards the partial window and the pointer
    do_reset();
    for (int k = 0; k < WIN_LEN; k++) push_pair(0, 4, k);
    run_windows(1, 40);
    for (int k = 0; k < WIN_LEN; k++) push_pair(1, 5, k);
    run_beats(3, 20);
    dones_before = done_cnt;
    do_reset();
    chk("rst_no_done", 32'(done_cnt), 32'(dones_before));
    for (int k = 0; k < WIN_LEN; k++) push_pair(0, 6, k + 8);
    for (int k = 0; k < WIN_LEN; k++) push_pair(1, 7, k + 8);
    run_windows(1, 40);
    chk("rst_next_tag", 32'(obs_tags[$]), 32'd0);
    chk("rst_next_beats", 32'(obs_beats[$]), 32'd4);
    run_windows(1, 40);

    // Grant lock: requester 0 shows up mid-window of requester 3
    do_reset();
    for (int k = 0; k < WIN_LEN; k++) push_pair(3, 3, k);
    run_beats(1, 20);
    for (int k = 0; k < WIN_LEN; k++) push_pair(0, 0, k);
    base = obs_tags.size();
    run_windows(2, 60);
    chk("lock_first", 32'(obs_tags[base]), 32'd3);
    chk("lock_second", 32'(obs_tags[base + 1]), 32'd0);

    // Random traffic with random backpressure
    do_reset();
    for (int t = 0; t < 600; t++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if ($urandom_range(0, 5) == 0 && srcq[r].size() < 6)
          repeat ($urandom_range(1, 4)) srcq[r].push_back(PW'($urandom_range(0, 255)));
      end
      wfull_drv = ($urandom_range(0, 3) == 0);
      tick(1'b0);
    end
    wfull_drv = 1'b0;
    pending = 1;
    for (int t = 0; t < 800 && pending != 0; t++) begin
      tick(1'b0);
      pending = (m_phase != M_ARB) ? 1 : 0;
      for (int r = 0; r < NUM_REQ; r++) if (srcq[r].size() > 0) pending = 1;
    end
    chk("drain", 32'(pending), 32'd0);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
